// File: rtl/btb_update_ctrl.sv
// Write-side controller for the 1024x32 BTB: a coalescing update queue that drains
// in fetch-idle cycles, forces a write after sustained starvation, and forwards pending targets.
module btb_update_ctrl #(
    parameter int DEPTH        = 4,
    parameter int STARVE_LIMIT = 8
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic        i_upd_valid,
    input  logic [31:0] i_upd_pc,
    input  logic [31:0] i_upd_target,
    output logic        o_upd_ready,
    input  logic        i_fetch_req,
    input  logic [31:0] i_fetch_pc,
    output logic        o_fetch_stall,
    output logic        o_fwd_hit,
    output logic [31:0] o_fwd_data,
    output logic        o_btb_wren,
    output logic [9:0]  o_btb_addr,
    output logic [31:0] o_btb_wdata
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam int STV_W = $clog2(STARVE_LIMIT + 1);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_PEND,
        ST_FORCE
    } state_e;

    state_e             state_q, state_d;
    logic [PTR_W-1:0]   head_q, head_d;
    logic [PTR_W-1:0]   tail_q, tail_d;
    logic [CNT_W-1:0]   count_q, count_d;
    logic [STV_W-1:0]   starve_q, starve_d;
    logic [9:0]         idx_q  [DEPTH];
    logic [9:0]         idx_d  [DEPTH];
    logic [31:0]        data_q [DEPTH];
    logic [31:0]        data_d [DEPTH];

    logic [9:0]         upd_idx, fetch_idx;
    logic [DEPTH-1:0]   vld, upd_match, fetch_match;
    logic               full, wren, accept, bypass, overwrite, alloc, blocked;
    logic               unused_pc_bits;

    assign upd_idx        = i_upd_pc[11:2];
    assign fetch_idx      = i_fetch_pc[11:2];
    assign unused_pc_bits = ^{i_upd_pc[31:12], i_upd_pc[1:0], i_fetch_pc[31:12], i_fetch_pc[1:0]};

    // Slot i is live when its distance from head (mod DEPTH) is below count.
    always_comb begin
        vld         = '0;
        upd_match   = '0;
        fetch_match = '0;
        for (int i = 0; i < DEPTH; i++) begin
            vld[i]         = {1'b0, PTR_W'(i) - head_q} < count_q;
            upd_match[i]   = vld[i] && (idx_q[i] == upd_idx);
            fetch_match[i] = vld[i] && (idx_q[i] == fetch_idx);
        end
    end

    assign full      = (count_q == CNT_W'(DEPTH));
    assign wren      = (count_q != '0) &&
                       ((state_q == ST_FORCE) || ((state_q == ST_PEND) && !i_fetch_req));
    assign accept    = i_upd_valid && o_upd_ready;
    assign bypass    = accept && wren && upd_match[head_q];
    assign overwrite = accept && (|upd_match) && !bypass;
    assign alloc     = accept && !(|upd_match);
    assign blocked   = (state_q == ST_PEND) && full && i_fetch_req;

    assign o_upd_ready   = !full || wren;
    assign o_btb_wren    = wren;
    assign o_fetch_stall = wren && (state_q == ST_FORCE);
    assign o_btb_addr    = wren ? idx_q[head_q] : fetch_idx;
    assign o_btb_wdata   = !wren ? '0 : (bypass ? i_upd_target : data_q[head_q]);
    assign o_fwd_hit     = |fetch_match;

    // Indices are unique, so OR-reducing the matching slots yields the single hit.
    always_comb begin
        o_fwd_data = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (fetch_match[i]) o_fwd_data = o_fwd_data | data_q[i];
        end
    end

    always_comb begin
        idx_d  = idx_q;
        data_d = data_q;
        for (int i = 0; i < DEPTH; i++) begin
            if (overwrite && upd_match[i]) data_d[i] = i_upd_target;
        end
        if (alloc) begin
            idx_d[tail_q]  = upd_idx;
            data_d[tail_q] = i_upd_target;
        end
        head_d  = head_q + PTR_W'(wren);
        tail_d  = tail_q + PTR_W'(alloc);
        count_d = count_q + CNT_W'(alloc) - CNT_W'(wren);
    end

    always_comb begin
        starve_d = '0;
        if (blocked && (starve_q != STV_W'(STARVE_LIMIT - 1))) starve_d = starve_q + 1'b1;
        if (count_d == '0)
            state_d = ST_IDLE;
        else if (blocked && (starve_q == STV_W'(STARVE_LIMIT - 1)))
            state_d = ST_FORCE;
        else
            state_d = ST_PEND;
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q  <= ST_IDLE;
            head_q   <= '0;
            tail_q   <= '0;
            count_q  <= '0;
            starve_q <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                idx_q[i]  <= '0;
                data_q[i] <= '0;
            end
        end else begin
            state_q  <= state_d;
            head_q   <= head_d;
            tail_q   <= tail_d;
            count_q  <= count_d;
            starve_q <= starve_d;
            idx_q    <= idx_d;
            data_q   <= data_d;
        end
    end

endmodule

// File: tb/tb_btb_update_ctrl.sv
// Randomized bench for btb_update_ctrl: a queue-based model checked every cycle,
// plus directed sequences with hand-computed literal expectations.
module tb_btb_update_ctrl;

    localparam int DEPTH = 4;
    localparam int LIMIT = 8;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        upd_valid = 1'b0;
    logic [31:0] upd_pc = '0;
    logic [31:0] upd_target = '0;
    logic        fetch_req = 1'b0;
    logic [31:0] fetch_pc = '0;
    logic        o_upd_ready, o_fetch_stall, o_fwd_hit, o_btb_wren;
    logic [31:0] o_fwd_data, o_btb_wdata;
    logic [9:0]  o_btb_addr;

    always #5 clk = ~clk;

    btb_update_ctrl #(.DEPTH(DEPTH), .STARVE_LIMIT(LIMIT)) dut (
        .i_clk        (clk),
        .i_rst_n      (rst_n),
        .i_upd_valid  (upd_valid),
        .i_upd_pc     (upd_pc),
        .i_upd_target (upd_target),
        .o_upd_ready  (o_upd_ready),
        .i_fetch_req  (fetch_req),
        .i_fetch_pc   (fetch_pc),
        .o_fetch_stall(o_fetch_stall),
        .o_fwd_hit    (o_fwd_hit),
        .o_fwd_data   (o_fwd_data),
        .o_btb_wren   (o_btb_wren),
        .o_btb_addr   (o_btb_addr),
        .o_btb_wdata  (o_btb_wdata)
    );

    int n_vec = 0;
    int n_mis = 0;

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_mis++;
            $display("FAIL %s at %0t: got %h expected %h", nm, $time, got, exp);
        end
    endtask

    // Reference model: the pending updates as an ordered list (front = oldest).
    typedef struct packed {
        logic [9:0]  idx;
        logic [31:0] data;
    } ent_t;

    ent_t        mq[$];
    ent_t        nq[$];
    int          m_starve = 0;
    bit          m_force = 1'b0;
    int          n_starve;
    bit          n_force;
    bit          have_next;
    logic [9:0]  fidx, uidx;
    logic        e_wren, e_stall, e_ready, e_hit, acc, byp, found;
    logic [31:0] e_fd, e_wdata;
    logic [9:0]  e_addr;

    always begin
        @(negedge clk);
        #2;
        have_next = 1'b0;
        if (!rst_n) begin
            chk("rst_wren", 32'(o_btb_wren), 32'd0);
            chk("rst_stall", 32'(o_fetch_stall), 32'd0);
            chk("rst_hit", 32'(o_fwd_hit), 32'd0);
            chk("rst_fwd", o_fwd_data, 32'd0);
            chk("rst_wdata", o_btb_wdata, 32'd0);
            chk("rst_ready", 32'(o_upd_ready), 32'd1);
            chk("rst_addr", 32'(o_btb_addr), 32'(fetch_pc[11:2]));
            mq.delete();
            m_starve = 0;
            m_force  = 1'b0;
        end else begin
            fidx    = fetch_pc[11:2];
            uidx    = upd_pc[11:2];
            e_wren  = (mq.size() > 0) && (m_force || !fetch_req);
            e_stall = e_wren && m_force;
            e_ready = (mq.size() < DEPTH) || e_wren;
            e_hit   = 1'b0;
            e_fd    = '0;
            foreach (mq[i]) if (mq[i].idx == fidx) begin
                e_hit = 1'b1;
                e_fd  = mq[i].data;
            end
            acc = upd_valid && e_ready;
            byp = 1'b0;
            if (acc && e_wren) byp = (mq[0].idx == uidx);
            e_wdata = '0;
            e_addr  = fidx;
            if (e_wren) begin
                e_wdata = byp ? upd_target : mq[0].data;
                e_addr  = mq[0].idx;
            end
            chk("wren", 32'(o_btb_wren), 32'(e_wren));
            chk("stall", 32'(o_fetch_stall), 32'(e_stall));
            chk("ready", 32'(o_upd_ready), 32'(e_ready));
            chk("fwd_hit", 32'(o_fwd_hit), 32'(e_hit));
            chk("fwd_data", o_fwd_data, e_fd);
            chk("addr", 32'(o_btb_addr), 32'(e_addr));
            chk("wdata", o_btb_wdata, e_wdata);

            nq = mq;
            if (e_wren) void'(nq.pop_front());
            if (acc && !byp) begin
                found = 1'b0;
                foreach (nq[i]) if (nq[i].idx == uidx) begin
                    nq[i].data = upd_target;
                    found = 1'b1;
                end
                if (!found) nq.push_back('{idx: uidx, data: upd_target});
            end
            n_force  = 1'b0;
            n_starve = 0;
            if (!e_wren && mq.size() == DEPTH && fetch_req) begin
                if (m_starve == LIMIT - 1) n_force = 1'b1;
                else n_starve = m_starve + 1;
            end
            have_next = 1'b1;
        end
        @(posedge clk or negedge rst_n);
        if (!rst_n) begin
            mq.delete();
            m_starve = 0;
            m_force  = 1'b0;
        end else if (have_next) begin
            mq       = nq;
            m_starve = n_starve;
            m_force  = n_force;
        end
    end

    task automatic drive(input bit v, input logic [31:0] pc, input logic [31:0] tgt,
                         input bit fr, input logic [31:0] fpc);
        @(negedge clk);
        upd_valid  = v;
        upd_pc     = pc;
        upd_target = tgt;
        fetch_req  = fr;
        fetch_pc   = fpc;
        #3;
    endtask

    logic [9:0] idx_tab [6] = '{10'h004, 10'h008, 10'h00C, 10'h3FF, 10'h000, 10'h155};

    initial begin
        logic [31:0] r, pc, fpc;
        int          fr_pct;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        // Single update drains on the next fetch-idle cycle.
        drive(1, 32'h0000_1004, 32'h0000_2000, 0, 0);
        chk("t1_ready", 32'(o_upd_ready), 32'd1);
        chk("t1_nowr", 32'(o_btb_wren), 32'd0);
        drive(0, 0, 0, 0, 0);
        chk("t1_wren", 32'(o_btb_wren), 32'd1);
        chk("t1_addr", 32'(o_btb_addr), 32'h001);
        chk("t1_wdata", o_btb_wdata, 32'h2000);
        drive(0, 0, 0, 0, 0);
        chk("t1_idle", 32'(o_btb_wren), 32'd0);

        // Fill under constant fetch pressure; starvation forces one write.
        drive(1, 32'h10, 32'h10, 1, 0);
        drive(1, 32'h20, 32'h20, 1, 0);
        drive(1, 32'h30, 32'h30, 1, 0);
        drive(1, 32'h40, 32'h40, 1, 0);
        for (int k = 0; k < LIMIT; k++) begin
            drive(0, 0, 0, 1, 32'h500);
            chk("t2_notready", 32'(o_upd_ready), 32'd0);
            chk("t2_nostall", 32'(o_fetch_stall), 32'd0);
        end
        drive(0, 0, 0, 1, 32'h500);
        chk("t2_stall", 32'(o_fetch_stall), 32'd1);
        chk("t2_wren", 32'(o_btb_wren), 32'd1);
        chk("t2_addr", 32'(o_btb_addr), 32'h004);
        chk("t2_wdata", o_btb_wdata, 32'h10);
        drive(0, 0, 0, 1, 32'h500);
        chk("t2_ready", 32'(o_upd_ready), 32'd1);
        chk("t2_stall_off", 32'(o_fetch_stall), 32'd0);
        for (int k = 0; k < 3; k++) begin
            drive(0, 0, 0, 0, 0);
            chk("t2_drain_addr", 32'(o_btb_addr), 32'(10'h008 + 10'(4 * k)));
        end
        drive(0, 0, 0, 0, 0);
        chk("t2_empty", 32'(o_btb_wren), 32'd0);

        // In-place coalescing.
        drive(1, 32'h10, 32'hAAAA, 1, 0);
        drive(1, 32'h10, 32'hBBBB, 1, 32'h10);
        chk("t3_old_fwd", o_fwd_data, 32'hAAAA);
        drive(0, 0, 0, 1, 32'h10);
        chk("t3_new_fwd", o_fwd_data, 32'hBBBB);
        drive(0, 0, 0, 0, 0);
        chk("t3_addr", 32'(o_btb_addr), 32'h004);
        chk("t3_wdata", o_btb_wdata, 32'hBBBB);
        drive(0, 0, 0, 0, 0);
        chk("t3_empty", 32'(o_btb_wren), 32'd0);

        // Bypass into a head that is being written.
        drive(1, 32'h20, 32'h1111, 1, 0);
        drive(1, 32'h20, 32'hCCCC, 0, 0);
        chk("t4_addr", 32'(o_btb_addr), 32'h008);
        chk("t4_wdata", o_btb_wdata, 32'hCCCC);
        drive(0, 0, 0, 0, 0);
        chk("t4_empty", 32'(o_btb_wren), 32'd0);

        // Forwarding hit and miss.
        drive(1, 32'hFFC, 32'h1234, 1, 0);
        drive(0, 0, 0, 1, 32'hFFC);
        chk("t5_hit", 32'(o_fwd_hit), 32'd1);
        chk("t5_data", o_fwd_data, 32'h1234);
        drive(0, 0, 0, 1, 32'h1000);
        chk("t5_miss", 32'(o_fwd_hit), 32'd0);
        chk("t5_zero", o_fwd_data, 32'd0);
        drive(0, 0, 0, 0, 0);
        chk("t5_addr", 32'(o_btb_addr), 32'h3FF);
        drive(0, 0, 0, 0, 0);

        // Reset mid-cycle with three pending entries.
        drive(1, 32'h10, 32'h1, 1, 32'h10);
        drive(1, 32'h20, 32'h2, 1, 32'h10);
        drive(1, 32'h30, 32'h3, 1, 32'h10);
        drive(0, 0, 0, 1, 32'h10);
        chk("t6_prehit", 32'(o_fwd_hit), 32'd1);
        rst_n = 1'b0;
        #1;
        chk("t6_hit", 32'(o_fwd_hit), 32'd0);
        chk("t6_ready", 32'(o_upd_ready), 32'd1);
        chk("t6_addr", 32'(o_btb_addr), 32'h004);
        @(negedge clk);
        rst_n = 1'b1;
        for (int k = 0; k < 3; k++) begin
            drive(0, 0, 0, 0, 32'h10);
            chk("t6_nowrite", 32'(o_btb_wren), 32'd0);
        end

        // Random traffic over a small index set to exercise coalescing and starvation.
        fr_pct = 90;
        for (int n = 0; n < 4000; n++) begin
            if (n % 64 == 0) fr_pct = ($urandom_range(0, 1) == 1) ? 95 : 30;
            r   = $urandom();
            pc  = {r[31:12], idx_tab[$urandom_range(0, 5)], r[1:0]};
            r   = $urandom();
            fpc = {r[31:12], ($urandom_range(0, 9) < 7) ? idx_tab[$urandom_range(0, 5)] : r[11:2],
                   r[1:0]};
            drive($urandom_range(0, 1) == 1, pc, $urandom(), $urandom_range(0, 99) < fr_pct, fpc);
            if ($urandom_range(0, 399) == 0) begin
                rst_n = 1'b0;
                #1;
                chk("rnd_rst_ready", 32'(o_upd_ready), 32'd1);
                chk("rnd_rst_wren", 32'(o_btb_wren), 32'd0);
                @(negedge clk);
                rst_n = 1'b1;
            end
        end

        repeat (2) @(negedge clk);
        #4;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
        $finish;
    end

endmodule

// File: doc/btb_update_ctrl.md
Name: btb_update_ctrl

Overview:
- Write-side controller for the 1024x32 branch target buffer RAM. The RAM has one shared address port; this block owns its address, write-enable and write-data.
- Accepts resolved-branch updates from EX and buffers them in a small coalescing queue.
- Drains one update per cycle into the BTB in cycles where fetch does not need a read.
- Forwards pending targets to fetch so a queued update is never missed by a lookup.

Parameters:
- DEPTH, 4, update queue entries (power of two, >=2)
- STARVE_LIMIT, 8, consecutive blocked cycles with a full queue before a write is forced (>=1)

Ports:
- i_clk  input  1  clock, all state on posedge
- i_rst_n  input  1  asynchronous active-low reset
- i_upd_valid  input  1  EX presents a resolved taken branch
- i_upd_pc  input  32  branch PC; BTB index = pc[11:2]
- i_upd_target  input  32  32-bit BTB entry to store (opaque to this block)
- o_upd_ready  output  1  update accepted this cycle when high with i_upd_valid
- i_fetch_req  input  1  fetch needs a BTB read this cycle
- i_fetch_pc  input  32  fetch PC; read index = pc[11:2]
- o_fetch_stall  output  1  fetch read slot taken by a forced write this cycle
- o_fwd_hit  output  1  fetch index matches a pending queue entry
- o_fwd_data  output  32  pending entry data when o_fwd_hit, else 0
- o_btb_wren  output  1  BTB write enable
- o_btb_addr  output  10  BTB address: write index when o_btb_wren, else i_fetch_pc[11:2]
- o_btb_wdata  output  32  BTB write data

Behaviour:
- Reset (async, i_rst_n=0): queue empty, count=0, starve counter=0, state IDLE.
- Reset output values: o_btb_wren=0, o_fetch_stall=0, o_fwd_hit=0, o_fwd_data=0, o_btb_wdata=0, o_upd_ready=1. o_btb_addr follows i_fetch_pc[11:2].
- Queue: FIFO of {idx[9:0], data[31:0]}; head = oldest entry. Indices in the queue are always unique.
- State IDLE: queue empty. Go to PEND when an update is accepted.
- State PEND: queue non-empty.
  - Write when i_fetch_req=0: o_btb_wren=1, addr/wdata = head; head popped at posedge.
  - Go to IDLE when the last entry is popped and nothing is enqueued in the same cycle.
- Starve counter:
  - Increments in PEND while count==DEPTH and i_fetch_req=1; clears on any write or when count<DEPTH.
  - Reaching STARVE_LIMIT-1 in a blocked cycle moves the state to FORCE next cycle.
- State FORCE: one cycle only.
  - o_btb_wren=1 and o_fetch_stall=1 regardless of i_fetch_req; head popped.
  - Next state is PEND, or IDLE if the queue is now empty. Counter clears.
- o_upd_ready = (count<DEPTH) | o_btb_wren. It does not depend on i_upd_valid or i_upd_pc.
- Accepted update, coalescing rules (in priority order):
  - Index equals head and head is written this cycle: o_btb_wdata = i_upd_target (bypass), head popped, no allocation.
  - Index equals any other pending entry: that entry's data is overwritten in place, no allocation.
  - Otherwise: allocate at tail.
- Enqueue and dequeue in the same cycle: count is unchanged. This is legal at full because ready covers it.
- Forwarding: combinational compare of i_fetch_pc[11:2] against all valid entries.
  - Entries are unique, so at most one matches.
  - An entry being popped this cycle still forwards this cycle.
  - Coalesced in-place data is visible from the next cycle.
- Pointers wrap modulo DEPTH. Count width is clog2(DEPTH)+1.
- No write issues when the queue is empty. o_btb_wdata = 0 whenever o_btb_wren=0.
- Reset mid-drain: a write in progress is abandoned and pending entries are lost. This is acceptable because the BTB is a hint only.

Test Plan:
- Reset, then pc=0x0000_1004 target=0x0000_2000 with i_fetch_req=0 -> cycle 1 accepted; cycle 2 o_btb_wren=1, o_btb_addr=0x001, o_btb_wdata=0x2000; state IDLE after.
- i_fetch_req=1 held; enqueue pcs 0x10, 0x20, 0x30, 0x40 -> o_upd_ready=0 once 4 are queued; STARVE_LIMIT=8 blocked cycles later, one FORCE cycle with o_fetch_stall=1, addr=0x004; then o_upd_ready=1.
- Queue holds idx 0x004 with data 0xAAAA; update pc=0x10 target 0xBBBB -> count unchanged; the later write of idx 0x004 carries 0xBBBB.
- Head idx 0x008 draining (fetch idle) while update pc=0x20 target 0xCCCC -> o_btb_wdata=0xCCCC that cycle, count decrements by 1.
- Queue holds idx 0x3FF data 0x1234; i_fetch_pc=0xFFC -> o_fwd_hit=1, o_fwd_data=0x1234. i_fetch_pc=0x1000 (idx 0) -> o_fwd_hit=0, o_fwd_data=0.
- 3 entries pending, i_rst_n pulsed low mid-cycle -> all outputs take their reset values immediately; no further writes after release.
